// File: rtl/pipe_wb_stage.sv
// pipe_wb_stage: two-entry skid-buffered writeback stage; PIPE_WB_FWD_EN adds a forwarding port
module pipe_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 6
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mo,
  input  logic [RN_W-1:0]   in_rn,
  input  logic              in_m2reg,
  input  logic              in_wreg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mo,
  output logic [RN_W-1:0]   out_rn,
  output logic              out_m2reg,
  output logic              out_wreg
`ifdef PIPE_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RN_W-1:0]   fwd_rn,
  output logic [DATA_W-1:0] fwd_data
`endif
);
  localparam int PW = 2*DATA_W + RN_W + 2;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic in_ready_q, in_xfer, out_xfer, wreg_raw;
  assign in_pl     = {in_alu, in_mo, in_rn, in_m2reg, in_wreg};
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;
  assign {out_alu, out_mo, out_rn, out_m2reg, wreg_raw} = main_q;
  assign out_wreg  = wreg_raw & (|out_rn);
`ifdef PIPE_WB_FWD_EN
  assign fwd_valid = out_valid & out_wreg;
  assign fwd_rn    = out_rn;
  assign fwd_data  = out_m2reg ? out_mo : out_alu;
`endif
  // next state and payload moves; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (in_xfer) begin
        state_d = ONE;
        main_d  = in_pl;
      end
      ONE: if (in_xfer && out_xfer) main_d = in_pl;
        else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_pl;
        end
        else if (out_xfer) state_d = EMPTY;
      FULL: if (out_xfer) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // state, payload and registered in_ready; async reset clears everything
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != FULL;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end
endmodule

// File: doc/pipe_wb_stage.md
PIPE_WB_STAGE -- requirements
Module: pipe_wb_stage

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, width of ALU result and memory output.
REQ-002 The block SHALL take parameter RN_W, default 6, width of the destination register number.
REQ-003 The block SHALL have clk, input, 1, sole clock, all state updates on the rising edge.
REQ-004 The block SHALL have clrn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have in_valid, input, 1, upstream payload valid.
REQ-006 The block SHALL have in_ready, output, 1, stage can accept a payload this cycle.
REQ-007 The block SHALL have in_alu, in_mo, input, DATA_W each, ALU result and memory output.
REQ-008 The block SHALL have in_rn, input, RN_W, destination register number.
REQ-009 The block SHALL have in_m2reg and in_wreg, input, 1 each, select-memory and register-write controls.
REQ-010 The block SHALL have flush, input, 1, synchronous discard of all held payloads.
REQ-011 The block SHALL have out_valid, output, 1, and out_ready, input, 1, downstream handshake.
REQ-012 The block SHALL have out_alu, out_mo (DATA_W), out_rn (RN_W), out_m2reg, out_wreg (1), all outputs, the held payload.

Function
REQ-013 The stage SHALL hold two entries, main and skid, and keep strict FIFO order; states EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE and 0 in FULL, never combinationally dependent on out_ready.
REQ-016 out_valid SHALL be 1 in ONE and FULL; outputs SHALL always present the main entry.
REQ-017 Latency SHALL be one cycle: a payload accepted in EMPTY appears on the outputs with out_valid=1 in the next cycle.
REQ-018 Transitions: EMPTY+in -> ONE; ONE+in, no out -> FULL; ONE+in+out -> ONE with new payload in main; ONE+out, no in -> EMPTY; FULL+out -> ONE with skid moved to main; FULL with no out -> FULL, outputs stable.
REQ-019 While out_valid=1 and out_ready=0, all out_* signals SHALL remain unchanged.
REQ-020 Sustained in_valid=1 and out_ready=1 SHALL give one transfer per cycle with no bubbles.
REQ-021 out_wreg SHALL be forced to 0 when out_rn is all zeros (register-zero write suppression); other fields pass unmodified.
REQ-022 flush=1 SHALL move the state to EMPTY at the next edge, set in_ready to 1, and discard any input accepted in the same cycle; flush has priority over all transfers.
REQ-023 Payload registers of invalid entries SHALL hold their last value; only valid bits and in_ready carry control meaning.

Reset
REQ-024 clrn=0 SHALL immediately force EMPTY, out_valid=0, in_ready=1, and out_alu, out_mo, out_rn, out_m2reg, out_wreg and the skid payload to 0, independent of clk.
REQ-025 Reset asserted mid-transfer SHALL discard both entries; the first rising edge after clrn returns to 1 SHALL behave as EMPTY.

Configuration
REQ-026 With macro PIPE_WB_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_rn (RN_W) and fwd_data (DATA_W), combinational from the main entry: fwd_valid = out_valid AND out_wreg, fwd_data = out_mo when out_m2reg=1 else out_alu, fwd_rn = out_rn.
REQ-027 Without PIPE_WB_FWD_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset: clrn=0 with in_valid=1 -> out_valid=0, in_ready=1, all out_* = 0; first edge after release with in_alu=0x11 -> out_alu=0x11, out_valid=1 next cycle.
REQ-029 Backpressure: out_ready=0, push A=0x1 and B=0x2 -> in_ready=0 after B, out_alu holds 0x1; raise out_ready -> 0x1 then 0x2 on consecutive cycles, in_ready=1 again.
REQ-030 Streaming: out_ready=1, push 0x10..0x1F on 16 consecutive cycles -> same 16 values out, in order, one per cycle, one-cycle latency.
REQ-031 Flush: state FULL, flush=1 with in_valid=1 in_alu=0x99 -> next cycle out_valid=0, in_ready=1, 0x99 never appears.
REQ-032 Zero register: in_rn=0, in_wreg=1 -> out_wreg=0; in_rn=5, in_wreg=1 -> out_wreg=1.
REQ-033 With PIPE_WB_FWD_EN: in_m2reg=1, in_mo=0xABCD, in_alu=0x1234, in_rn=3, in_wreg=1 -> fwd_valid=1, fwd_rn=3, fwd_data=0xABCD; with in_m2reg=0 -> fwd_data=0x1234.
